// File: rtl/xps2_rx_pkg.sv
// xps2_rx_pkg: register offsets, STATUS/CTRL bit positions and receiver FSM states.
package xps2_rx_pkg;
  localparam logic [1:0] XPS2_DATA = 2'd0, XPS2_STATUS = 2'd1, XPS2_CTRL = 2'd2;
  localparam int ST_NE = 0, ST_FULL = 1, ST_PAR = 2, ST_FRM = 3, ST_OVF = 4, ST_CNT = 8;
  localparam int CT_EN = 0, CT_IRQ = 1;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;
endpackage

// File: rtl/xps2_fifo.sv
// xps2_fifo: synchronous FIFO with explicit count so full and empty are unambiguous.
module xps2_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  logic pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic full_o,
  output logic empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic do_push, do_pop;
  assign do_pop = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign empty_o = cnt_q == '0;
  assign full_o = cnt_q == CW'(DEPTH);
  assign dout_o = mem_q[rd_q];
  assign count_o = cnt_q;
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(do_push);
      rd_q <= rd_q + AW'(do_pop);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/xps2_rx.sv
// xps2_rx: memory-mapped PS/2 receiver with byte FIFO and level interrupt.
// Define XPS2_TIMEOUT_EN to abort frames whose clock stalls for TIMEOUT_CYC cycles.
module xps2_rx
  import xps2_rx_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int FILT_LEN = 4,
  parameter int TIMEOUT_CYC = 2000
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  input  logic sel,
  input  logic rw_rnw,
  input  logic [1:0] rw_addr,
  input  logic [DATA_W-1:0] data_to_wr,
  output logic [DATA_W-1:0] data_to_rd,
  output logic irq
);
  localparam int FCW = $clog2(FILT_LEN+1);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  logic [1:0] c_sync_q, d_sync_q;
  logic filt_q, filt_prev_q;
  logic [FCW-1:0] filt_cnt_q;
  state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d, head;
  logic par_q, par_d;
  logic [1:0] ctrl_q, ctrl_d;
  logic par_err_q, par_err_d, frm_err_q, frm_err_d, ovf_q, ovf_d;
  logic fall, frame_ok, par_bad, frm_bad, timeout, pop, push, full, empty, wr_st, unused_w;
  logic [CW-1:0] count;
  logic [DATA_W-1:0] status;
  assign fall = filt_prev_q & ~filt_q;
  assign pop = sel & rw_rnw & (rw_addr == XPS2_DATA) & ~empty;
  assign wr_st = sel & ~rw_rnw & (rw_addr == XPS2_STATUS);
  assign push = frame_ok & (~full | pop);
  assign irq = ctrl_q[CT_IRQ] & ~empty;
  assign unused_w = ^data_to_wr[DATA_W-1:5];
  // Filtered level flips only on the FILT_LEN-th consecutive differing sample
  always_ff @(posedge clk)
    if (!rst) begin
      c_sync_q <= '1;
      d_sync_q <= '1;
      filt_q <= 1'b1;
      filt_prev_q <= 1'b1;
      filt_cnt_q <= '0;
    end else begin
      c_sync_q <= {c_sync_q[0], ps2_clk};
      d_sync_q <= {d_sync_q[0], ps2_data};
      filt_prev_q <= filt_q;
      filt_cnt_q <= (c_sync_q[1] == filt_q || filt_cnt_q == FCW'(FILT_LEN-1)) ? '0 : filt_cnt_q + 1'b1;
      if (c_sync_q[1] != filt_q && filt_cnt_q == FCW'(FILT_LEN-1)) filt_q <= c_sync_q[1];
    end
`ifdef XPS2_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC+1);
  logic [TW-1:0] to_q;
  assign timeout = (state_q != IDLE) && (to_q == TW'(TIMEOUT_CYC));
  always_ff @(posedge clk)
    to_q <= (!rst || state_q == IDLE || fall || timeout) ? '0 : to_q + 1'b1;
`else
  assign timeout = (TIMEOUT_CYC < 0);
`endif
  always_comb begin
    state_d = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d = shift_q;
    par_d = par_q;
    par_bad = 1'b0;
    frm_bad = 1'b0;
    frame_ok = 1'b0;
    if (!ctrl_q[CT_EN]) state_d = IDLE;
    else if (timeout) begin
      state_d = IDLE;
      frm_bad = 1'b1;
    end else if (fall)
      case (state_q)
        IDLE: begin
          state_d = d_sync_q[1] ? IDLE : DATA;
          bit_cnt_d = '0;
        end
        DATA: begin
          shift_d[bit_cnt_q] = d_sync_q[1];
          bit_cnt_d = bit_cnt_q + 1'b1;
          state_d = (bit_cnt_q == 3'd7) ? PARITY : DATA;
        end
        PARITY: begin
          par_d = d_sync_q[1];
          state_d = STOP;
        end
        default: begin
          par_bad = ~^{shift_q, par_q};
          frm_bad = ~d_sync_q[1];
          frame_ok = ~par_bad & ~frm_bad;
          state_d = IDLE;
        end
      endcase
  end
  // Sticky flags: a new error wins over a same-cycle W1C
  assign par_err_d = par_bad | (par_err_q & ~(wr_st & data_to_wr[ST_PAR]));
  assign frm_err_d = frm_bad | (frm_err_q & ~(wr_st & data_to_wr[ST_FRM]));
  assign ovf_d = (frame_ok & ~push) | (ovf_q & ~(wr_st & data_to_wr[ST_OVF]));
  assign ctrl_d = (sel & ~rw_rnw & (rw_addr == XPS2_CTRL)) ? data_to_wr[1:0] : ctrl_q;
  always_ff @(posedge clk)
    if (!rst) begin
      state_q <= IDLE;
      bit_cnt_q <= '0;
      shift_q <= '0;
      par_q <= 1'b0;
      ctrl_q <= '0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q <= shift_d;
      par_q <= par_d;
      ctrl_q <= ctrl_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
      ovf_q <= ovf_d;
    end
  xps2_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push_i(push), .pop_i(pop), .din_i(shift_q),
    .dout_o(head), .full_o(full), .empty_o(empty), .count_o(count)
  );
  always_comb begin
    status = '0;
    status[ST_NE] = ~empty;
    status[ST_FULL] = full;
    status[ST_PAR] = par_err_q;
    status[ST_FRM] = frm_err_q;
    status[ST_OVF] = ovf_q;
    status[ST_CNT +: CW] = count;
    data_to_rd = (rw_addr == XPS2_DATA) ? DATA_W'({~empty, empty ? 8'h00 : head}) :
                 (rw_addr == XPS2_STATUS) ? status :
                 (rw_addr == XPS2_CTRL) ? DATA_W'(ctrl_q) : '0;
  end
endmodule
